// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 restoring divide, shift-add multiply.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 product.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at accept
  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, accept;

  always_comb begin
    is_div   = op_i[2];
    a_signed = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_signed = is_div ? ~op_i[0] : ~op_i[1];
    sign_a   = a_signed & src_a_i[XLEN-1];
    sign_b   = b_signed & src_b_i[XLEN-1];
    a_mag    = sign_a ? -src_a_i : src_a_i;
    b_mag    = sign_b ? -src_b_i : src_b_i;
    div_zero = (src_b_i == '0);
    div_ovf  = ~op_i[0] && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
    accept   = start_i && ((state_q == StIdle) || (state_q == StDone));
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
  logic                     unused_fast;
  always_comb begin
    fast_a    = {{(XLEN+1){sign_a}}, src_a_i};
    fast_b    = {{(XLEN+1){sign_b}}, src_b_i};
    fast_prod = fast_a * fast_b;
  end
  assign unused_fast = ^fast_prod[2*XLEN+1:2*XLEN];
`endif

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up for the final result
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_d    = op_i;
          sa_d    = sign_a;
          sb_d    = sign_b;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          opb_d   = is_div ? b_mag : a_mag;
          state_d = StCalc;
          if (is_div && div_zero) begin
            result_d = op_i[1] ? src_a_i : '1;
            state_d  = StDone;
          end else if (is_div && div_ovf) begin
            result_d = op_i[1] ? '0 : src_a_i;
            state_d  = StDone;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = (op_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                            : fast_prod[2*XLEN-1:XLEN];
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == 6'd31) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StFin: begin
        if (op_q[2]) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end else begin
          result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over any accept or completion in the same cycle
    if (flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == StCalc) || (state_q == StFin);
  assign valid_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: divide, special cases, multiply,
// flush, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

  localparam logic [2:0] OpMul = 3'b000, OpMulh = 3'b001, OpMulhsu = 3'b010, OpMulhu = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, valid;
  logic [31:0] result;
  int          checks = 0;
  int          failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .flush_i  (flush),
    .op_i     (op),
    .src_a_i  (a),
    .src_b_i  (b),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for valid; lat counts edges since the accept edge, -1 on timeout.
  task automatic wait_valid(input int lat_in, output int lat);
    lat = lat_in;
    while (!valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid) lat = -1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(1, lat);
    r = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    run_op(OpDiv, 32'd20, 32'hFFFF_FFFD, r, lat);
    checks++; if (r !== 32'hFFFF_FFFA) begin failures++; $display("FAIL div_neg: got %h want fffffffa", r); end
    checks++; if (lat != 34) begin failures++; $display("FAIL div_latency: got %0d want 34", lat); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL valid_pulse: got %b want 0", valid); end
    run_op(OpRem, 32'd20, 32'hFFFF_FFFD, r, lat);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL rem_neg: got %h want 2", r); end
    run_op(OpDivu, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu: got %h want e", r); end
    run_op(OpRemu, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu: got %h want 2", r); end
    run_op(OpRem, 32'hFFFF_FFEC, 32'd3, r, lat);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL rem_negdividend: got %h want fffffffe", r); end
  endtask

  task automatic test_div_special();
    logic [31:0] r;
    int lat;
    run_op(OpDivu, 32'd5, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero: got %h want ffffffff", r); end
    checks++; if (lat != 1) begin failures++; $display("FAIL divzero_latency: got %0d want 1", lat); end
    run_op(OpRem, 32'd5, 32'd0, r, lat);
    checks++; if (r !== 32'd5) begin failures++; $display("FAIL rem_zero: got %h want 5", r); end
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf: got %h want 80000000", r); end
    checks++; if (lat != 1) begin failures++; $display("FAIL ovf_latency: got %0d want 1", lat); end
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf: got %h want 0", r); end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    run_op(OpMulh, 32'h8000_0000, 32'h8000_0000, r, lat);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL mulh: got %h want 40000000", r); end
    checks++; if (lat != MulLat) begin failures++; $display("FAIL mul_latency: got %0d want %0d", lat, MulLat); end
    run_op(OpMul, 32'h8000_0000, 32'h8000_0000, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL mul_low: got %h want 0", r); end
    run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu: got %h want fffffffe", r); end
    run_op(OpMulhsu, 32'hFFFF_FFFF, 32'h0000_0002, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu: got %h want ffffffff", r); end
    run_op(OpMul, 32'd7, 32'hFFFF_FFFD, r, lat);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_neg: got %h want ffffffeb", r); end
    checks++; if (lat != MulLat) begin failures++; $display("FAIL mul_latency2: got %0d want %0d", lat, MulLat); end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int lat;
    int nvalid;
    run_op(OpDivu, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL flush_prior: got %h want e", r); end
    @(negedge clk);
    op = OpDiv; a = 32'd20; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    // Flush with a simultaneous start; the start must be dropped
    flush = 1'b1; start = 1'b1; op = OpDivu; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", valid); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL flush_result: got %h want e", result); end
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin failures++; $display("FAIL flush_novalid: got %0d want 0", nvalid); end
    run_op(OpDivu, 32'd9, 32'd3, r, lat);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL after_flush: got %h want 3", r); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op = OpDivu; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(1, lat);
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL b2b_first: got %h want e", result); end
    op = OpDivu; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b want 1", busy); end
    repeat (3) @(posedge clk);
    #1;
    op = OpDivu; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++; $display("FAIL calc_start_ignored: got busy=%b valid=%b want busy=1 valid=0", busy, valid);
    end
    wait_valid(5, lat);
    checks++; if (lat != 34) begin failures++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    checks++; if (result !== 32'd3) begin failures++; $display("FAIL b2b_second: got %h want 3", result); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = OpDiv; a = 32'd20; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b want 0", valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result: got %h want 0", result); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_div_special();
    test_mul();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV32 M extension. It is the multi-cycle counterpart to the single-cycle execute ALU: the execute stage hands it two operands and an M-extension op with a start pulse, stalls while `busy_o` is high, and takes the result on a one-cycle `valid_o` pulse. Division results follow the RISC-V specification exactly, including divide-by-zero and signed overflow.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request; accepted only in IDLE or DONE.
- `flush_i`  in  1  synchronous abort of any operation in flight.
- `op_i`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a_i`  in  32  rs1 operand (multiplicand/dividend); sampled at accept.
- `src_b_i`  in  32  rs2 operand (multiplier/divisor); sampled at accept.
- `busy_o`  out  1  high in CALC and FIN.
- `valid_o`  out  1  one-cycle pulse; `result_o` is valid while it is high.
- `result_o`  out  32  result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIN, DONE.
- Priority at each edge: reset first, then flush, then normal operation.
- Reset: state = IDLE; `busy_o` = 0, `valid_o` = 0, `result_o` = 0; counter and datapath registers cleared.
- Flush: state = IDLE and `valid_o` = 0; `result_o` unchanged; a `start_i` in the same cycle is ignored.
- Accept: on `start_i` in IDLE or DONE, latch `op_i`, the operands and the operand signs.
  - Signed ops convert operands to magnitudes.
  - MULHSU treats only `src_a_i` as signed; MULHU, DIVU and REMU treat both as unsigned.
- `start_i` while `busy_o` = 1 is ignored; the issuing stage must stall.
- Special divide cases (detected at accept; go directly to DONE):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; the REM form returns 0.
- Divide: radix-2 restoring, one quotient bit per cycle, 6-bit counter, 32 iterations in CALC.
  - FIN negates the quotient if the operand signs differ (DIV).
  - FIN negates the remainder if the dividend is negative (REM).
- Multiply without FAST_MUL_EN: shift-add, 32 iterations in CALC on a 64-bit accumulator.
  - FIN negates the 64-bit product if the effective signs differ.
  - MUL selects bits [31:0]; the MULH variants select bits [63:32].
- DONE: `valid_o` = 1 for exactly one cycle, then IDLE unless a new start is accepted.
- A start accepted in DONE gives back-to-back operation with no bubble.

## Timing
- Accept edge = edge 0.
- Iterative op: edges 1–32 are CALC iterations (counter 0→31, CALC→FIN at edge 32); edge 33 does FIN→DONE.
  - `valid_o` is high in the cycle after edge 33, so latency is 34 cycles.
  - `busy_o` is high from edge 0 until edge 33.
- Special divide case: DONE at edge 0; `valid_o` in the cycle after edge 0 (latency 1); `busy_o` never high.
- `result_o` is registered and updates on the edge that enters DONE.
- No combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiplies use one registered signed 33×33-bit product (sign/zero-extended per op) computed at accept.
  - Operation goes IDLE→DONE at edge 0; latency 1; `busy_o` never high for multiplies.
  - Divide behaviour is unchanged.
- Not defined: multiplies use the 34-cycle iterative path; no hardware multiplier is inferred.

## Test plan
- DIV 20 / 0xFFFFFFFD → 0xFFFFFFFA after 34 cycles; REM on the same operands → 2; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF with latency 1; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MUL on the same operands → 0; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Check latency 34 without the macro and 1 with it.
- MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF; MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
- `flush_i` at iteration 10 of a DIV → IDLE next cycle, `valid_o` never asserts, `result_o` keeps its prior value; a new DIVU 9 / 3 right after returns 3.
- `start_i` asserted in the DONE cycle → new op accepted with no idle cycle; `start_i` during CALC ignored; `rst_i` mid-divide → all outputs 0 next cycle.
